// File: rtl/register_file_wb_pkg.sv
// Shared defaults and helpers for the register-file write-back arbiter.
package register_file_wb_pkg;

  localparam int unsigned RF_WB_WORD_LENGTH = 8;
  localparam int unsigned RF_WB_REG_AMOUNT  = 8;
  localparam int unsigned RF_WB_NUM_REQ     = 2;
  localparam int unsigned RF_WB_FIFO_DEPTH  = 2;

  // Candidate index for the offset-th slot of a round-robin search after 'last'.
  function automatic int unsigned rr_index(int unsigned last, int unsigned offset,
                                           int unsigned n);
    return (last + 1 + offset) % n;
  endfunction

endpackage

// File: rtl/register_file_wb_fifo.sv
// Per-producer circular-buffer FIFO holding {addr, data} write entries.
module register_file_wb_fifo #(
  parameter int unsigned Width = 11,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  assign full  = (cnt_q == CntW'(Depth));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  push_when_full_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  pop_when_empty_a: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/register_file_wb_arbiter.sv
// Round-robin write-back arbiter feeding the register file's single write port
// from per-producer FIFOs, with registered write outputs.
module register_file_wb_arbiter
  import register_file_wb_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = RF_WB_WORD_LENGTH,
  parameter int unsigned REG_AMOUNT  = RF_WB_REG_AMOUNT,
  parameter int unsigned NUM_REQ     = RF_WB_NUM_REQ,
  parameter int unsigned FIFO_DEPTH  = RF_WB_FIFO_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*$clog2(REG_AMOUNT)-1:0]  req_addr,
  input  logic [NUM_REQ*WORD_LENGTH-1:0]         req_data,
  output logic                                   wrEn,
  output logic [$clog2(REG_AMOUNT)-1:0]          addrWrite,
  output logic [WORD_LENGTH-1:0]                 dataIn,
  output logic [$clog2(NUM_REQ)-1:0]             grant_id,
  output logic                                   busy
);

  localparam int unsigned AW     = $clog2(REG_AMOUNT);
  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned EntryW = AW + WORD_LENGTH;

  logic [NUM_REQ-1:0] full, empty, push, pop;
  logic [EntryW-1:0]  head [NUM_REQ];
  logic [EntryW-1:0]  win_head;
  logic               gnt_valid;
  logic [IdW-1:0]     winner, cand;

  logic                   wr_en_q, wr_en_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic [IdW-1:0]         gid_q, gid_d;
  logic [IdW-1:0]         rr_last_q, rr_last_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    assign push[i] = req_valid[i] & ~full[i];

    register_file_wb_fifo #(
      .Width(EntryW),
      .Depth(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push[i]),
      .wdata({req_addr[i*AW +: AW], req_data[i*WORD_LENGTH +: WORD_LENGTH]}),
      .pop  (pop[i]),
      .full (full[i]),
      .empty(empty[i]),
      .head (head[i])
    );
  end

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign req_ready = ~full;

  always_comb begin
    gnt_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    pop       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdW'(rr_index(32'(rr_last_q), k, NUM_REQ));
      if (!gnt_valid && !empty[cand]) begin
        gnt_valid = 1'b1;
        winner    = cand;
      end
    end
    if (gnt_valid) begin
      pop[winner] = 1'b1;
    end
  end

  assign win_head = head[winner];

  always_comb begin
    wr_en_d   = gnt_valid;
    addr_d    = addr_q;
    data_d    = data_q;
    gid_d     = gid_q;
    rr_last_d = rr_last_q;
    if (gnt_valid) begin
      addr_d    = win_head[EntryW-1:WORD_LENGTH];
      data_d    = win_head[WORD_LENGTH-1:0];
      gid_d     = winner;
      rr_last_d = winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      gid_q     <= '0;
      rr_last_q <= IdW'(NUM_REQ - 1);
    end else begin
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      gid_q     <= gid_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign wrEn      = wr_en_q;
  assign addrWrite = addr_q;
  assign dataIn    = data_q;
  assign grant_id  = gid_q;
  assign busy      = ~(&empty) | wr_en_q;

endmodule
